seq_divider: RTL
================

# seq_divider

Iterative restoring unsigned divider: the inverse of the team's shift-and-add multiplier, same start/done handshake, one quotient bit per clock. Accepts a WIDTH-bit dividend and divisor on a `start` pulse. After WIDTH cycles it presents a WIDTH-bit quotient and remainder, held until the next operation. Used where DSP/divider macros are unavailable or area matters more than latency.

## Interface
- `WIDTH`, default 8: operand, quotient and remainder width (≥2).

- `clk`  input  1  single clock; all state updates on rising edge.
- `rst`  input  1  asynchronous, active-high reset; clears all state immediately.
- `start`  input  1  begin an operation; sampled only when not busy.
- `dividend`  input  WIDTH  unsigned numerator, captured on accepted `start`.
- `divisor`  input  WIDTH  unsigned denominator, captured on accepted `start`.
- `quotient`  output  WIDTH  unsigned result; valid while `done`=1.
- `remainder`  output  WIDTH  unsigned result; valid while `done`=1.
- `busy`  output  1  high while iterating.
- `done`  output  1  level; high from completion until the next accepted `start`.
- `div_by_zero`  output  1  qualifies `done`; high if captured divisor was 0.

## Operation
- FSM states: IDLE, RUN, DONE. Reset state is IDLE.
- IDLE/DONE + `start`=1: capture operands. Clear `done` and `div_by_zero`. Load the working quotient register Q = dividend and the partial remainder R (WIDTH+1 bits) = 0. Load the bit counter = WIDTH.
  - Divisor ≠ 0: go to RUN.
  - Divisor = 0: go directly to DONE on the next edge (no iterations).
- IDLE/DONE + `start`=0: hold state and all outputs.
- RUN, each edge:
  - Shift {R,Q} left by 1, with R taking Q's MSB.
  - Trial T = shifted R − {1'b0, divisor} in WIDTH+1 bits.
  - If T non-negative (MSB 0): R ← T and Q LSB ← 1. Otherwise R keeps the shifted value and Q LSB ← 0.
  - Decrement the counter. When the counter reaches 1 on this edge, the next state is DONE.
- RUN + `start`: ignored. Operands already captured are used; no restart.
- DONE entry:
  - `quotient` ← Q, `remainder` ← R[WIDTH-1:0], `done` ← 1.
  - Divide by zero: `quotient` = all ones, `remainder` = captured dividend, `div_by_zero` = 1.
- Outputs are registered and hold in DONE until the next accepted `start`.
- Invariant on normal completion: dividend = quotient·divisor + remainder, with remainder < divisor.

## Timing
- Reset values: `quotient`=0, `remainder`=0, `busy`=0, `done`=0, `div_by_zero`=0. FSM=IDLE, counter=0, R=0, Q=0.
- Capture edge E0 (`start` high in IDLE/DONE). After E0: `busy`=1, `done`=0.
- Iterations occur on edges E1..EWIDTH. After EWIDTH: `busy`=0, `done`=1, results valid.
- Latency: WIDTH cycles from the capture edge to `done` (8 for the default).
- Divide by zero: after E0 `busy`=1. After E1 `done`=1, `div_by_zero`=1, `busy`=0. Latency 1 cycle.
- `busy` and `done` are never both high.
- Back-to-back: `start` high in the cycle `done` is first seen is accepted. `done` drops on that edge; the new result follows WIDTH cycles later. No idle cycle is required.
- Operands need to be stable only at the capture edge; later changes have no effect.
- `rst` asserted at any time, including mid-RUN: all state and outputs go to reset values asynchronously. `start` is ignored while `rst` is high. Operation resumes from IDLE on the first edge after deassertion.

## Test plan
- Reset mid-operation:
  - Stimulus: assert `rst` 3 cycles into a 100/7 run.
  - Response: all outputs 0 immediately.
  - Follow-up: after release, a 9/3 operation gives quotient 3, remainder 0.
- Basic divide, WIDTH=8:
  - Stimulus: start with 100/7.
  - Response: `busy` for 8 cycles, then `done`=1, quotient 14, remainder 2, `div_by_zero`=0. Results held for 5 further idle cycles.
- Boundary operands:
  - 255/1 → 255 r 0.
  - 0/5 → 0 r 0.
  - 200/255 → 0 r 200.
  - 255/255 → 1 r 0.
  - Each has latency exactly 8 cycles.
- Divide by zero:
  - Stimulus: 13/0.
  - Response: `done` and `div_by_zero` after 1 cycle, quotient 255, remainder 13.
  - Follow-up: a subsequent 13/4 clears `div_by_zero` and gives 3 r 1.
- Handshake:
  - `start` pulsed with 50/3 during RUN of 100/7: ignored; result is 14 r 2.
  - `start` with 50/3 in the first DONE cycle: accepted with no gap; result is 16 r 2, 8 cycles later.
- Randomized sweep, WIDTH=8 and WIDTH=16:
  - Stimulus: 1000 random operand pairs, including divisor 0.
  - Response: check the identity dividend = q·d + r with r < d, the divide-by-zero rules, and latency on every result.

Source files
------------

// File: rtl/seq_divider.sv
// seq_divider: iterative restoring unsigned divider.
// One quotient bit per clock, start/done handshake.
module seq_divider #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] dvsr_q;
  logic             dz_q;

  logic             accept;
  logic             last;
  logic [WIDTH:0]   sh_r;
  logic [WIDTH:0]   trial;
  logic             fits;
  logic [WIDTH-1:0] r_nx;
  logic [WIDTH-1:0] q_nx;

  // A start is only honoured when no division is in flight.
  assign accept = start && (state != S_RUN);
  assign last   = (cnt == CW'(1));
  assign busy   = (state == S_RUN);

  // One restoring step: shift {R,Q}, trial-subtract, keep or restore.
  // R stays below the divisor, so WIDTH bits hold it between steps.
  always_comb begin
    sh_r  = {r_q, q_q[WIDTH-1]};
    trial = sh_r - {1'b0, dvsr_q};
    fits  = ~trial[WIDTH];
    r_nx  = fits ? trial[WIDTH-1:0]
                 : sh_r[WIDTH-1:0];
    q_nx  = {q_q[WIDTH-2:0], fits};
  end

  // Control FSM and bit counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (accept) begin
            state <= S_RUN;
            cnt   <= CW'(WIDTH);
          end
        end
        S_RUN: begin
          if (dz_q) begin
            state <= S_DONE;
          end else begin
            cnt <= cnt - CW'(1);
            if (last) state <= S_DONE;
          end
        end
        default: begin
          state <= S_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  // Working registers: operand capture, then one step per RUN edge.
  // A zero divisor skips iteration; Q keeps the dividend for the
  // remainder report.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q    <= '0;
      q_q    <= '0;
      dvsr_q <= '0;
      dz_q   <= 1'b0;
    end else if (accept) begin
      r_q    <= '0;
      q_q    <= dividend;
      dvsr_q <= divisor;
      dz_q   <= (divisor == '0);
    end else if (state == S_RUN && !dz_q) begin
      r_q <= r_nx;
      q_q <= q_nx;
    end
  end

  // Result registers: loaded on DONE entry, held until next start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      quotient    <= '0;
      remainder   <= '0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
    end else if (accept) begin
      done        <= 1'b0;
      div_by_zero <= 1'b0;
    end else if (state == S_RUN) begin
      if (dz_q) begin
        quotient    <= '1;
        remainder   <= q_q;
        done        <= 1'b1;
        div_by_zero <= 1'b1;
      end else if (last) begin
        quotient    <= q_nx;
        remainder   <= r_nx;
        done        <= 1'b1;
        div_by_zero <= 1'b0;
      end
    end
  end

endmodule
